fft_frame_arb: RTL and testbench
================================

FFT_FRAME_ARB -- requirements
Module: fft_frame_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of each Re/Im half; word width W = 2*DATA_W.
REQ-002 SHALL have parameter LOGN, default 10, frame length N = 2**LOGN samples.
REQ-003 SHALL have parameter NREQ, default 2, number of requesters; legal range 2..4.
REQ-004 SHALL have parameter TAG_DEPTH, default 2, number of frames in flight (owner-tag FIFO depth); legal range 1..4.
REQ-005 SHALL have clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have rst_i  input  1  reset, synchronous and active-high.
REQ-007 SHALL have req_valid_i  input  NREQ  per-requester input sample valid.
REQ-008 SHALL have req_data_i  input  NREQ*W  per-requester sample {Re,Im}; requester k occupies bits [k*W +: W].
REQ-009 SHALL have req_ready_o  output  NREQ  per-requester input sample accept.
REQ-010 SHALL have fft_in_valid_o / fft_in_data_o / fft_in_ready_i  out/out/in  1/W/1  sample stream into the FFT core.
REQ-011 SHALL have fft_out_valid_i / fft_out_data_i / fft_out_ready_o  in/in/out  1/W/1  result stream from the FFT core.
REQ-012 SHALL have rsp_valid_o  output  NREQ  per-requester result valid.
REQ-013 SHALL have rsp_data_o  output  W  result data, shared by all requesters.
REQ-014 SHALL have rsp_ready_i  input  NREQ  per-requester result accept.
REQ-015 SHALL have in_owner_o  output  clog2(NREQ)  index of the requester holding the input grant.
REQ-016 SHALL have busy_o  output  1  high while IN_FRAME is active or the tag FIFO is non-empty.

Function
REQ-017 SHALL implement an input FSM with states IDLE and IN_FRAME.
REQ-018 In IDLE, with tag FIFO not full and any req_valid_i high, SHALL grant round-robin: first valid index at or after pointer rr_q, wrapping at NREQ.
REQ-019 On grant, SHALL register the owner, push the owner index into the tag FIFO, set rr_q = (owner+1) mod NREQ, and enter IN_FRAME; arbitration costs exactly 1 cycle.
REQ-020 In IDLE, SHALL drive all req_ready_o low and fft_in_valid_o low.
REQ-021 In IDLE with tag FIFO full, SHALL not grant even if requests are pending.
REQ-022 In IN_FRAME, SHALL drive, combinationally and with no added latency: fft_in_valid_o = req_valid_i[owner], fft_in_data_o = req_data_i[owner], req_ready_o[owner] = fft_in_ready_i; all other req_ready_o SHALL be 0.
REQ-023 SHALL keep a LOGN-bit input counter incremented on each fft_in handshake.
REQ-024 On the handshake at count N-1, SHALL clear the counter and return to IDLE; the grant is never preempted mid-frame.
REQ-025 On the output side, when the tag FIFO is non-empty with head tag t: rsp_valid_o[t] = fft_out_valid_i, rsp_data_o = fft_out_data_i, fft_out_ready_o = rsp_ready_i[t], and all other rsp_valid_o are 0.
REQ-026 With the tag FIFO empty, SHALL drive fft_out_ready_o = 0 and all rsp_valid_o = 0.
REQ-027 SHALL keep a LOGN-bit output counter incremented on each fft_out handshake; on the handshake at count N-1 it SHALL clear and pop the tag FIFO.
REQ-028 On a simultaneous tag push (grant) and pop (last output) in one cycle, occupancy SHALL remain unchanged and both operations SHALL take effect.
REQ-029 in_owner_o SHALL hold the last granted index, including while in IDLE.
REQ-030 SHALL ignore rsp_ready_i of non-head requesters.

Reset
REQ-031 With rst_i high at a clock edge, the block SHALL enter IDLE, set rr_q = 0, clear both counters, empty the tag FIFO, and set in_owner_o = 0.
REQ-032 While in reset state: all req_ready_o, rsp_valid_o, fft_in_valid_o, fft_out_ready_o and busy_o SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame with no partial-frame bookkeeping retained.

Verification (LOGN=2, N=4, NREQ=2, TAG_DEPTH=2)
REQ-034 Single requester: req0 streams 4 samples with fft_in_ready_i=1 -> 1-cycle arbitration gap, then 4 consecutive transfers; tag 0 pushed; 4 outputs appear only on rsp_valid_o[0]; busy_o falls after the 4th output handshake.
REQ-035 Contention: req0 and req1 both valid continuously from reset -> frames are granted in order 0,1,0,1; in_owner_o follows this sequence; results are routed to the matching requester.
REQ-036 Tag full: two frames fed in, fft_out_valid_i held 0 -> third grant is withheld (req_ready_o = 00) until the 4th output of frame 1 pops its tag.
REQ-037 Backpressure: fft_in_ready_i toggles 1,0,1,0 and rsp_ready_i[0] held 0 for 3 cycles -> no sample is lost or duplicated, and the counters advance only on handshakes.
REQ-038 Reset mid-frame: rst_i pulsed after 2 of 4 input samples -> all outputs are 0 next cycle, the next grant goes to req0, and a full 4-sample frame is required again.

Source files
------------

// File: rtl/fft_frame_arb.sv
// Frame-level arbiter in front of a streaming FFT core: grants whole
// N-sample frames to one requester and routes results back by owner tag.
module fft_frame_arb #(
   parameter int DATA_W    = 16,
   parameter int LOGN      = 10,
   parameter int NREQ      = 2,
   parameter int TAG_DEPTH = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NREQ-1:0]            req_valid_i,
   input  logic [NREQ*2*DATA_W-1:0]   req_data_i,
   output logic [NREQ-1:0]            req_ready_o,
   output logic                       fft_in_valid_o,
   output logic [2*DATA_W-1:0]        fft_in_data_o,
   input  logic                       fft_in_ready_i,
   input  logic                       fft_out_valid_i,
   input  logic [2*DATA_W-1:0]        fft_out_data_i,
   output logic                       fft_out_ready_o,
   output logic [NREQ-1:0]            rsp_valid_o,
   output logic [2*DATA_W-1:0]        rsp_data_o,
   input  logic [NREQ-1:0]            rsp_ready_i,
   output logic [$clog2(NREQ)-1:0]    in_owner_o,
   output logic                       busy_o
);

   localparam int W  = 2 * DATA_W;
   localparam int OW = $clog2(NREQ);
   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int CW = $clog2(TAG_DEPTH + 1);
   localparam logic [LOGN-1:0] LAST = '1;

   typedef enum logic {IDLE, IN_FRAME} state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   rr_q, rr_d;
   logic [OW-1:0]   rr_pick;
   logic [OW:0]     cand;
   logic [LOGN-1:0] in_cnt_q, in_cnt_d;
   logic [LOGN-1:0] out_cnt_q;
   logic [OW-1:0]   tag_mem [TAG_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   occ_q;
   logic [OW-1:0]   head;
   logic            tag_full, tag_empty;
   logic            grant, in_hs, out_hs, pop;

   assign tag_empty = (occ_q == '0);
   assign tag_full  = (occ_q == CW'(TAG_DEPTH));
   assign head      = tag_mem[rd_ptr_q];

   // Descending scan so the smallest offset from rr_q wins.
   always_comb begin
      rr_pick = rr_q;
      cand    = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         cand = {1'b0, rr_q} + (OW+1)'(i);
         if (cand >= (OW+1)'(NREQ))
            cand = cand - (OW+1)'(NREQ);
         if (req_valid_i[cand[OW-1:0]])
            rr_pick = cand[OW-1:0];
      end
   end

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      rr_d           = rr_q;
      in_cnt_d       = in_cnt_q;
      grant          = 1'b0;
      in_hs          = 1'b0;
      req_ready_o    = '0;
      fft_in_valid_o = 1'b0;
      fft_in_data_o  = req_data_i[int'(owner_q)*W +: W];
      unique case (state_q)
         IDLE: begin
            if (!tag_full && |req_valid_i) begin
               grant   = 1'b1;
               owner_d = rr_pick;
               rr_d    = (rr_pick == OW'(NREQ - 1)) ? '0
                         : rr_pick + OW'(1);
               state_d = IN_FRAME;
            end
         end
         IN_FRAME: begin
            fft_in_valid_o       = req_valid_i[owner_q];
            req_ready_o[owner_q] = fft_in_ready_i;
            in_hs = req_valid_i[owner_q] & fft_in_ready_i;
            if (in_hs) begin
               in_cnt_d = in_cnt_q + LOGN'(1);
               if (in_cnt_q == LAST)
                  state_d = IDLE;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      rsp_valid_o     = '0;
      fft_out_ready_o = 1'b0;
      if (!tag_empty) begin
         rsp_valid_o[head] = fft_out_valid_i;
         fft_out_ready_o   = rsp_ready_i[head];
      end
   end

   assign rsp_data_o = fft_out_data_i;
   assign out_hs     = fft_out_valid_i & fft_out_ready_o;
   assign pop        = out_hs & (out_cnt_q == LAST);
   assign in_owner_o = owner_q;
   assign busy_o     = (state_q == IN_FRAME) | ~tag_empty;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         rr_q      <= '0;
         in_cnt_q  <= '0;
         out_cnt_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         in_cnt_q <= in_cnt_d;
         if (out_hs)
            out_cnt_q <= out_cnt_q + LOGN'(1);
         if (grant)
            wr_ptr_q <= (wr_ptr_q == PW'(TAG_DEPTH - 1)) ? '0
                        : wr_ptr_q + PW'(1);
         if (pop)
            rd_ptr_q <= (rd_ptr_q == PW'(TAG_DEPTH - 1)) ? '0
                        : rd_ptr_q + PW'(1);
         if (grant && !pop)
            occ_q <= occ_q + CW'(1);
         else if (pop && !grant)
            occ_q <= occ_q - CW'(1);
      end
   end

   // Tag storage needs no reset; occupancy decides what is live.
   always_ff @(posedge clk_i) begin
      if (grant)
         tag_mem[wr_ptr_q] <= rr_pick;
   end

endmodule

// File: tb/tb_fft_frame_arb.sv
// Bench for fft_frame_arb: requester sources, a FIFO FFT core model and
// a scoreboard that routes expected results by requester index.
module tb_fft_frame_arb;

   localparam int DATA_W    = 16;
   localparam int LOGN      = 2;
   localparam int NREQ      = 2;
   localparam int TAG_DEPTH = 2;
   localparam int W         = 2 * DATA_W;
   localparam int N         = 1 << LOGN;

   logic            clk = 1'b0;
   logic            rst_i;
   logic [1:0]      req_valid_i;
   logic [2*W-1:0]  req_data_i;
   logic [1:0]      req_ready_o;
   logic            fft_in_valid_o;
   logic [W-1:0]    fft_in_data_o;
   logic            fft_in_ready_i;
   logic            fft_out_valid_i;
   logic [W-1:0]    fft_out_data_i;
   logic            fft_out_ready_o;
   logic [1:0]      rsp_valid_o;
   logic [W-1:0]    rsp_data_o;
   logic [1:0]      rsp_ready_i;
   logic [0:0]      in_owner_o;
   logic            busy_o;

   int errors = 0;
   int checks = 0;
   int in_cnt = 0;
   int out_cnt = 0;
   int src_left [2] = '{0, 0};
   int src_seq  [2] = '{0, 0};

   logic       rst_k    = 1'b1;
   logic       in_rdy_k = 1'b0;
   logic       in_tog   = 1'b0;
   logic       tog_ph   = 1'b0;
   logic       out_en_k = 1'b0;
   logic [1:0] rsp_rdy_k = 2'b00;

   logic [W-1:0]   core_q  [$];
   logic [W-1:0]   exp_in  [$];
   logic [W+7:0]   exp_rsp [$];

   always #5 clk = ~clk;

   fft_frame_arb #(
      .DATA_W(DATA_W), .LOGN(LOGN), .NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .req_valid_i(req_valid_i),
      .req_data_i(req_data_i),
      .req_ready_o(req_ready_o),
      .fft_in_valid_o(fft_in_valid_o),
      .fft_in_data_o(fft_in_data_o),
      .fft_in_ready_i(fft_in_ready_i),
      .fft_out_valid_i(fft_out_valid_i),
      .fft_out_data_i(fft_out_data_i),
      .fft_out_ready_o(fft_out_ready_o),
      .rsp_valid_o(rsp_valid_o),
      .rsp_data_o(rsp_data_o),
      .rsp_ready_i(rsp_ready_i),
      .in_owner_o(in_owner_o),
      .busy_o(busy_o)
   );

   function automatic logic [W-1:0] mk_data(int k, int s);
      logic [31:0] sv;
      sv = s;
      return {8'(k + 1), 8'hA5, sv[15:0]};
   endfunction

   // Agent: drives inputs after posedge, samples handshakes at negedge.
   initial begin
      forever begin
         rst_i = rst_k;
         tog_ph = ~tog_ph;
         for (int k = 0; k < NREQ; k++) begin
            req_valid_i[k] = (src_left[k] > 0);
            req_data_i[k*W +: W] = mk_data(k, src_seq[k]);
         end
         fft_in_ready_i  = in_tog ? tog_ph : in_rdy_k;
         fft_out_valid_i = out_en_k && (core_q.size() > 0);
         fft_out_data_i  = (core_q.size() > 0) ? ~core_q[0] : '0;
         rsp_ready_i     = rsp_rdy_k;
         @(negedge clk);
         if (rst_i) begin
            exp_in.delete();
            exp_rsp.delete();
            core_q.delete();
         end else begin
            for (int k = 0; k < NREQ; k++) begin
               if (req_valid_i[k] && req_ready_o[k]) begin
                  exp_in.push_back(mk_data(k, src_seq[k]));
                  exp_rsp.push_back({8'(k), ~mk_data(k, src_seq[k])});
                  src_left[k]--;
                  src_seq[k]++;
               end
            end
            if (fft_in_valid_o && fft_in_ready_i) begin
               in_cnt++;
               checks++;
               if (exp_in.size() == 0) begin
                  errors++;
                  $display("FAIL sb_in: got %h want none", fft_in_data_o);
               end else if (fft_in_data_o !== exp_in[0]) begin
                  errors++;
                  $display("FAIL sb_in: got %h want %h",
                           fft_in_data_o, exp_in[0]);
               end
               if (exp_in.size() > 0)
                  void'(exp_in.pop_front());
               core_q.push_back(fft_in_data_o);
            end
            if (fft_out_valid_i && fft_out_ready_o)
               void'(core_q.pop_front());
            for (int j = 0; j < NREQ; j++) begin
               if (rsp_valid_o[j] && rsp_ready_i[j]) begin
                  out_cnt++;
                  checks++;
                  if (exp_rsp.size() == 0) begin
                     errors++;
                     $display("FAIL sb_rsp: got req%0d %h want none",
                              j, rsp_data_o);
                  end else if ({8'(j), rsp_data_o} !== exp_rsp[0]) begin
                     errors++;
                     $display("FAIL sb_rsp: got %h want %h",
                              {8'(j), rsp_data_o}, exp_rsp[0]);
                  end
                  if (exp_rsp.size() > 0)
                     void'(exp_rsp.pop_front());
               end
            end
         end
         @(posedge clk);
         #1;
      end
   end

   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_k = 1'b1;
      src_left[0] = 0;
      src_left[1] = 0;
      in_rdy_k = 1'b0;
      in_tog = 1'b0;
      out_en_k = 1'b0;
      rsp_rdy_k = 2'b00;
      repeat (3) @(negedge clk);
      #1;
      rst_k = 1'b0;
      in_cnt = 0;
      out_cnt = 0;
      wait_neg();
   endtask

   task automatic test_reset();
      rst_k = 1'b1;
      src_left[0] = 100;
      src_left[1] = 100;
      in_rdy_k = 1'b1;
      out_en_k = 1'b1;
      rsp_rdy_k = 2'b11;
      repeat (3) wait_neg();
      checks++;
      if (req_ready_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_req_ready: got %b want 00", req_ready_o);
      end
      checks++;
      if (rsp_valid_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid_o);
      end
      checks++;
      if (fft_in_valid_o !== 1'b0 || fft_out_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_fft: got %b%b want 00",
                  fft_in_valid_o, fft_out_ready_o);
      end
      checks++;
      if (busy_o !== 1'b0 || in_owner_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy_owner: got %b%b want 00",
                  busy_o, in_owner_o);
      end
   endtask

   task automatic test_single();
      do_reset();
      src_left[0] = N;
      in_rdy_k = 1'b1;
      out_en_k = 1'b1;
      rsp_rdy_k = 2'b11;
      wait_neg();
      checks++;
      if (req_ready_o !== 2'b00 || fft_in_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL single_arb: got %b %b %b want 00 0 0",
                  req_ready_o, fft_in_valid_o, busy_o);
      end
      for (int c = 0; c < N; c++) begin
         wait_neg();
         checks++;
         if (req_ready_o !== 2'b01 || fft_in_valid_o !== 1'b1 || in_owner_o !== 1'b0) begin
            errors++;
            $display("FAIL single_xfer%0d: got %b %b %b want 01 1 0",
                     c, req_ready_o, fft_in_valid_o, in_owner_o);
         end
      end
      wait_neg();
      checks++;
      if (req_ready_o !== 2'b00 || in_cnt !== N) begin
         errors++;
         $display("FAIL single_end: got %b cnt=%0d want 00 cnt=%0d",
                  req_ready_o, in_cnt, N);
      end
      for (int c = 0; c < 50 && out_cnt < N; c++)
         wait_neg();
      checks++;
      if (out_cnt !== N || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_hi: got out=%0d busy=%b want %0d 1",
                  out_cnt, busy_o, N);
      end
      wait_neg();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_lo: got %b want 0", busy_o);
      end
   endtask

   task automatic test_contention();
      int g;
      int k_in;
      logic last;
      do_reset();
      src_left[0] = 2 * N;
      src_left[1] = 2 * N;
      in_rdy_k = 1'b1;
      out_en_k = 1'b1;
      rsp_rdy_k = 2'b11;
      g = 0;
      k_in = 0;
      last = 1'b0;
      for (int c = 0; c < 200 && (g < 4 || out_cnt < 4 * N); c++) begin
         wait_neg();
         if (fft_in_valid_o && fft_in_ready_i) begin
            if (k_in % N == 0) begin
               checks++;
               if (in_owner_o !== 1'(g % 2)) begin
                  errors++;
                  $display("FAIL contention_grant%0d: got %0d want %0d",
                           g, in_owner_o, g % 2);
               end
               last = 1'(g % 2);
               g++;
            end
            k_in++;
         end else if (req_ready_o == 2'b00) begin
            checks++;
            if (in_owner_o !== last) begin
               errors++;
               $display("FAIL contention_hold: got %0d want %0d",
                        in_owner_o, last);
            end
         end
      end
      checks++;
      if (g != 4 || out_cnt != 4 * N) begin
         errors++;
         $display("FAIL contention_done: got g=%0d out=%0d want 4 %0d",
                  g, out_cnt, 4 * N);
      end
   endtask

   task automatic test_tag_full();
      int x;
      int gcyc;
      do_reset();
      src_left[0] = 100;
      src_left[1] = 100;
      in_rdy_k = 1'b1;
      rsp_rdy_k = 2'b11;
      for (int c = 0; c < 100 && in_cnt < 2 * N; c++)
         wait_neg();
      checks++;
      if (in_cnt != 2 * N) begin
         errors++;
         $display("FAIL full_fill: got %0d want %0d", in_cnt, 2 * N);
      end
      for (int c = 0; c < 5; c++) begin
         wait_neg();
         checks++;
         if (req_ready_o !== 2'b00 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL full_hold%0d: got %b %b want 00 1",
                     c, req_ready_o, busy_o);
         end
      end
      out_en_k = 1'b1;
      x = -1;
      gcyc = -1;
      for (int c = 0; c < 100 && gcyc < 0; c++) begin
         wait_neg();
         if (x < 0 && out_cnt >= N)
            x = c;
         if (req_ready_o != 2'b00)
            gcyc = c;
      end
      checks++;
      if (x < 0 || gcyc != x + 2) begin
         errors++;
         $display("FAIL full_release: got grant@%0d pop@%0d want pop+2",
                  gcyc, x);
      end
      checks++;
      if (req_ready_o !== 2'b01 || in_owner_o !== 1'b0) begin
         errors++;
         $display("FAIL full_third: got %b %0d want 01 0",
                  req_ready_o, in_owner_o);
      end
   endtask

   task automatic test_backpressure();
      int held;
      logic released;
      do_reset();
      src_left[0] = N;
      in_tog = 1'b1;
      out_en_k = 1'b1;
      rsp_rdy_k = 2'b10;
      held = 0;
      released = 1'b0;
      for (int c = 0; c < 100 && out_cnt < N; c++) begin
         wait_neg();
         if (fft_in_valid_o) begin
            checks++;
            if (req_ready_o !== {1'b0, fft_in_ready_i}) begin
               errors++;
               $display("FAIL bp_ready: got %b want 0%b",
                        req_ready_o, fft_in_ready_i);
            end
         end
         if (fft_out_valid_i && !released) begin
            checks++;
            if (fft_out_ready_o !== 1'b0 || rsp_valid_o !== 2'b01) begin
               errors++;
               $display("FAIL bp_hold: got %b %b want 0 01",
                        fft_out_ready_o, rsp_valid_o);
            end
            held++;
            if (held == 3) begin
               rsp_rdy_k = 2'b11;
               released = 1'b1;
            end
         end
      end
      checks++;
      if (in_cnt != N || out_cnt != N) begin
         errors++;
         $display("FAIL bp_counts: got in=%0d out=%0d want %0d %0d",
                  in_cnt, out_cnt, N, N);
      end
      wait_neg();
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_busy: got %b want 0", busy_o);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      src_left[0] = 100;
      in_rdy_k = 1'b1;
      rsp_rdy_k = 2'b11;
      for (int c = 0; c < 50 && in_cnt < 2; c++)
         wait_neg();
      rst_k = 1'b1;
      src_left[1] = 100;
      wait_neg();
      rst_k = 1'b0;
      wait_neg();
      checks++;
      if (req_ready_o !== 2'b00 || rsp_valid_o !== 2'b00 ||
          fft_in_valid_o !== 1'b0 || fft_out_ready_o !== 1'b0 ||
          busy_o !== 1'b0 || in_owner_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_outputs: got %b %b %b %b %b %b want all 0",
                  req_ready_o, rsp_valid_o, fft_in_valid_o,
                  fft_out_ready_o, busy_o, in_owner_o);
      end
      for (int c = 0; c < N; c++) begin
         wait_neg();
         checks++;
         if (req_ready_o !== 2'b01 || in_owner_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_regrant%0d: got %b %0d want 01 0",
                     c, req_ready_o, in_owner_o);
         end
      end
      wait_neg();
      checks++;
      if (req_ready_o !== 2'b00) begin
         errors++;
         $display("FAIL mid_frame_len: got %b want 00", req_ready_o);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_tag_full();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
